seg7_bcd_sequencer: RTL and testbench

Sequential front end for the four-digit 7-segment display path. It accepts a binary value on a start handshake and converts it to four digit codes: decimal via iterative shift-add-3 (double dabble, one bit per clock), or hexadecimal via a direct nibble split. It also produces a leading-zero blank mask and an overflow flag. Digit outputs are 7-bit codes (0..15) that drive the per-digit 7-segment converters directly. Display registers change only at conversion completion, so the display never shows partial results.

---
 rtl/seg7_bcd_sequencer_if.sv | 42 ++++
 rtl/seg7_bcd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_seg7_bcd_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_sequencer_if.sv
// ============================================================================
//  Module   : seg7_bcd_sequencer_if
//  Purpose  : Bundles the request and display-result signals of the
//             seg7_bcd_sequencer so that requester and converter share a
//             single port.
//  Ports    : master - drives start/value/hex_mode/blank_lz, observes results
//             slave  - the converter side (inverse directions)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_bcd_sequencer_if #(
    parameter int WIDTH = 14
);
    // Request side
    logic             start;
    logic [WIDTH-1:0] value;
    logic             hex_mode;
    logic             blank_lz;

    // Status and display side
    logic             busy;
    logic             done;
    logic             ovf;
    logic [6:0]       dig3;
    logic [6:0]       dig2;
    logic [6:0]       dig1;
    logic [6:0]       dig0;
    logic [3:0]       blank;

    modport master (
        output start, value, hex_mode, blank_lz,
        input  busy, done, ovf, dig3, dig2, dig1, dig0, blank
    );

    modport slave (
        input  start, value, hex_mode, blank_lz,
        output busy, done, ovf, dig3, dig2, dig1, dig0, blank
    );
endinterface

`default_nettype wire

// File: rtl/seg7_bcd_sequencer.sv
// ============================================================================
//  Module   : seg7_bcd_sequencer
//  Purpose  : Converts a WIDTH-bit binary value into four display digit codes.
//             Decimal mode runs a one-bit-per-clock double-dabble conversion;
//             hex mode splits the value into nibbles in a single step. Also
//             produces a leading-zero blank mask and a decimal overflow flag.
//             Display registers change only on entry to DONE.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - seg7_bcd_sequencer_if.slave
//                    start/value/hex_mode/blank_lz in,
//                    busy/done/ovf/dig3..dig0/blank out
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_bcd_sequencer #(
    parameter int WIDTH = 14
) (
    input  wire                  clk,
    input  wire                  rst,
    seg7_bcd_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [15:0]        r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic               r_blz;
    logic               r_busy;
    logic               r_done;

    logic               r_ovf;
    logic [3:0]         r_dig3;
    logic [3:0]         r_dig2;
    logic [3:0]         r_dig1;
    logic [3:0]         r_dig0;
    logic [3:0]         r_blank;

    logic [15:0]        w_adj;
    logic [15:0]        w_bcd_nx;
    logic [WIDTH-1:0]   w_sh_nx;
    logic [15:0]        w_val16;
    logic               w_last_shift;
    logic               w_hex_load;
    logic               w_load;
    logic [15:0]        w_fin;
    logic               w_fin_blz;
    logic               w_fin_ovf;
    logic [3:0]         w_blank;

    // ------------------------------------------------------------------
    // Double-dabble step: correct every BCD nibble >= 5 before the shift
    // so that it carries correctly into the next decimal digit.
    // ------------------------------------------------------------------
    always_comb begin
        w_adj = r_bcd;
        for (int n = 0; n < 4; n++) begin
            if (r_bcd[4*n +: 4] >= 4'd5) begin
                w_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_nx = {w_adj[14:0], r_shreg[WIDTH-1]};
    assign w_sh_nx  = {r_shreg[WIDTH-2:0], 1'b0};
    assign w_val16  = {{(16-WIDTH){1'b0}}, bus.value};

    assign w_last_shift = (r_state == S_SHIFT) && (r_cnt == CNT_W'(1));
    assign w_hex_load   = (r_state != S_SHIFT) && bus.start && bus.hex_mode;
    assign w_load       = w_last_shift || w_hex_load;

    // The final digits come either from the completing shift (decimal,
    // saturated to 9999 on overflow) or straight from the input (hex).
    assign w_fin     = (r_state == S_SHIFT) ? (r_ovf_pend ? 16'h9999 : w_bcd_nx)
                                            : w_val16;
    assign w_fin_blz = (r_state == S_SHIFT) ? r_blz : bus.blank_lz;
    assign w_fin_ovf = (r_state == S_SHIFT) ? r_ovf_pend : 1'b0;

    // Blanking propagates from the most significant digit and stops at the
    // first non-zero digit; the least significant digit is always shown.
    assign w_blank[3] = w_fin_blz  && (w_fin[15:12] == 4'd0);
    assign w_blank[2] = w_blank[3] && (w_fin[11:8]  == 4'd0);
    assign w_blank[1] = w_blank[2] && (w_fin[7:4]   == 4'd0);
    assign w_blank[0] = 1'b0;

    // ------------------------------------------------------------------
    // Control FSM with registered busy/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_blz      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start && bus.hex_mode) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (bus.start) begin
                        r_shreg    <= bus.value;
                        r_bcd      <= '0;
                        r_cnt      <= CNT_W'(WIDTH);
                        r_ovf_pend <= (w_val16 > 16'd9999);
                        r_blz      <= bus.blank_lz;
                        r_state    <= S_SHIFT;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_nx;
                    r_shreg <= w_sh_nx;
                    r_cnt   <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display registers: only written on the edge entering DONE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            r_dig3  <= '0;
            r_dig2  <= '0;
            r_dig1  <= '0;
            r_dig0  <= '0;
            r_blank <= '0;
        end else if (w_load) begin
            r_ovf   <= w_fin_ovf;
            r_dig3  <= w_fin[15:12];
            r_dig2  <= w_fin[11:8];
            r_dig1  <= w_fin[7:4];
            r_dig0  <= w_fin[3:0];
            r_blank <= w_blank;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.ovf   = r_ovf;
    assign bus.dig3  = {3'b000, r_dig3};
    assign bus.dig2  = {3'b000, r_dig2};
    assign bus.dig1  = {3'b000, r_dig1};
    assign bus.dig0  = {3'b000, r_dig0};
    assign bus.blank = r_blank;

endmodule

`default_nettype wire

// File: tb/tb_seg7_bcd_sequencer.sv
// ============================================================================
//  Module   : tb_seg7_bcd_sequencer
//  Purpose  : Self-checking bench for seg7_bcd_sequencer. Expected results
//             come from an arithmetic reference model and are queued when a
//             request is driven; a monitor pops and compares on every done.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_bcd_sequencer;

    localparam int WIDTH = 14;

    typedef struct {
        logic [6:0] d3;
        logic [6:0] d2;
        logic [6:0] d1;
        logic [6:0] d0;
        logic [3:0] blank;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seg7_bcd_sequencer_if #(.WIDTH(WIDTH)) bus ();

    seg7_bcd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain decimal arithmetic / nibble extraction
    function automatic exp_t model(input int v, input bit hx, input bit blz);
        exp_t e;
        int d3, d2, d1, d0;
        int vv;
        logic b3, b2, b1;
        vv = v & ((1 << WIDTH) - 1);
        e.ovf = 1'b0;
        if (hx) begin
            d3 = (vv >> 12) & 15; d2 = (vv >> 8) & 15;
            d1 = (vv >> 4) & 15;  d0 = vv & 15;
        end else if (vv > 9999) begin
            d3 = 9; d2 = 9; d1 = 9; d0 = 9;
            e.ovf = 1'b1;
        end else begin
            d3 = vv / 1000; d2 = (vv / 100) % 10;
            d1 = (vv / 10) % 10; d0 = vv % 10;
        end
        b3 = blz && (d3 == 0);
        b2 = b3 && (d2 == 0);
        b1 = b2 && (d1 == 0);
        e.d3 = 7'(d3); e.d2 = 7'(d2); e.d1 = 7'(d1); e.d0 = 7'(d0);
        e.blank = {b3, b2, b1, 1'b0};
        e.cyc = 0;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_done: observed done=1 at cycle %0d expected no done", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("dig3", bus.dig3, e.d3);
                chk("dig2", bus.dig2, e.d2);
                chk("dig1", bus.dig1, e.d1);
                chk("dig0", bus.dig0, e.d0);
                chk("blank", bus.blank, e.blank);
                chk("ovf", bus.ovf, e.ovf);
            end
        end
    end

    // One complete request; busy is checked every cycle of the conversion
    task automatic conv(input int v, input bit hx, input bit blz);
        exp_t e;
        int   s;
        int   last;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.value    = WIDTH'(v);
        bus.hex_mode = hx;
        bus.blank_lz = blz;
        s = cyc + 1;
        e = model(v, hx, blz);
        e.cyc = hx ? s : s + WIDTH;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        last = hx ? 2 : WIDTH + 2;
        for (int r = 1; r <= last; r++) begin
            chk("busy", bus.busy, (!hx && r <= WIDTH) ? 1 : 0);
            if (r < last) @(negedge clk);
        end
        chk("done_seen", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   s;
        bus.start    = 1'b0;
        bus.value    = '0;
        bus.hex_mode = 1'b0;
        bus.blank_lz = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_dig", {bus.dig3, bus.dig2, bus.dig1, bus.dig0}, 0);
        chk("rst_blank", bus.blank, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Decimal, blanking, overflow, hex
        conv(1234, 1'b0, 1'b0);
        conv(45, 1'b0, 1'b1);
        conv(0, 1'b0, 1'b1);
        conv(1000, 1'b0, 1'b1);
        conv(16383, 1'b0, 1'b0);
        conv(9999, 1'b0, 1'b0);
        conv(10000, 1'b0, 1'b1);
        conv(32'h3A5F, 1'b1, 1'b0);
        conv(32'h0005, 1'b1, 1'b1);
        conv(32'h0F00, 1'b1, 1'b1);

        // Start while busy is ignored; start in DONE is accepted
        @(negedge clk);
        bus.start = 1'b1; bus.value = WIDTH'(1234); bus.hex_mode = 1'b0; bus.blank_lz = 1'b0;
        s = cyc + 1;
        e = model(1234, 1'b0, 1'b0);
        e.cyc = s + WIDTH;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.value = WIDTH'(42);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_ignored_start", bus.busy, 1);
        repeat (9) @(negedge clk);
        chk("busy_in_done", bus.busy, 0);
        bus.start = 1'b1; bus.value = WIDTH'(42); bus.blank_lz = 1'b1;
        e = model(42, 1'b0, 1'b1);
        e.cyc = s + 2 * WIDTH + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_back_to_back", bus.busy, 1);
        repeat (15) @(negedge clk);
        chk("b2b_done_seen", sb.size(), 0);

        // Reset mid-conversion aborts with cleared display and no done
        @(negedge clk);
        bus.start = 1'b1; bus.value = WIDTH'(8765); bus.hex_mode = 1'b0; bus.blank_lz = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_dig", {bus.dig3, bus.dig2, bus.dig1, bus.dig0}, 0);
        chk("abort_blank", bus.blank, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        conv(8765, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
